riscv_lsu_align: RTL
====================

RISCV_LSU_ALIGN -- requirements
Module: riscv_lsu_align

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 64, address width in bits.
REQ-003 SHALL define NB = XLEN/8, bytes per bus beat (local, not overridable).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready.
REQ-008 SHALL have ports req_write / req_read  input  1 each  store / load request.
REQ-009 SHALL have port func_code  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  XLEN  store data, right-justified.
REQ-012 SHALL have port mem_valid  output  1  bus beat request.
REQ-013 SHALL have port mem_ready  input  1  beat accepted; for reads, mem_rdata is valid in the same cycle.
REQ-014 SHALL have ports mem_write output 1, mem_addr output ADDR_W (NB-aligned), mem_wdata output XLEN, mem_mask output NB (byte strobes).
REQ-015 SHALL have port mem_rdata  input  XLEN  read beat data.
REQ-016 SHALL have ports resp_valid output 1 (one-cycle pulse), resp_rdata output XLEN, resp_error output 1, resp_split output 1.

Function
REQ-017 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL, on acceptance, register op, func_code, addr and wdata, and go to BEAT0 on the next cycle; mem_valid SHALL NOT assert in the acceptance cycle.
REQ-019 SHALL compute size = 1<<func_code[1:0] bytes and off = addr[log2(NB)-1:0]; split = (off+size > NB).
REQ-020 SHALL flag an error, with no bus beat, for: func_code 111; func_code 011 when XLEN=32; func_code 1xx with req_write; req_read==req_write. Error requests go IDLE->RESP with resp_error=1 and resp_rdata=0.
REQ-021 SHALL in BEAT0 drive mem_addr = addr with low log2(NB) bits cleared, mem_mask = ((1<<size)-1)<<off truncated to NB, and mem_wdata = wdata<<(8*off) truncated to XLEN.
REQ-022 SHALL in BEAT1 (split only) drive mem_addr = BEAT0 address + NB (wrapping modulo 2^ADDR_W), mem_mask = ((1<<size)-1)>>(NB-off), and mem_wdata = wdata>>(8*(NB-off)).
REQ-023 SHALL hold mem_valid and all mem_* outputs stable until mem_ready; BEAT0->BEAT1 on handshake if split, else BEAT0->RESP; BEAT1->RESP on handshake.
REQ-024 SHALL for loads capture mem_rdata>>(8*off) at the BEAT0 handshake and OR in mem_rdata<<(8*(NB-off)) at the BEAT1 handshake, then keep the low size bytes.
REQ-025 SHALL sign-extend the load result when func_code[2]=0 and zero-extend when func_code[2]=1; D is passed through unchanged.
REQ-026 SHALL in RESP assert resp_valid for exactly one cycle with resp_split=split, then return to IDLE; store responses give resp_rdata=0.
REQ-027 SHALL drive mem_mask=0, mem_wdata=0 and mem_valid=0 in IDLE and RESP.
REQ-028 SHALL complete an unsplit access in a minimum of 3 cycles from acceptance to resp_valid, and a split access in a minimum of 4.

Reset
REQ-029 SHALL on rst go to IDLE and clear every output register: req_ready=1; mem_valid, mem_write, mem_addr, mem_wdata, mem_mask, resp_*=0.
REQ-030 SHALL on rst mid-access (any state) abandon the access with no resp_valid; mem_valid SHALL be 0 from the first cycle after the reset edge.

Verification (XLEN=64, mem_ready=1 unless stated)
REQ-031 SW addr 0x1004, wdata 0xDEADBEEF -> one beat: mem_addr 0x1000, mask 0xF0, wdata 0xDEADBEEF00000000; resp_split=0.
REQ-032 SD addr 0x1003, wdata 0x1122334455667788 -> beat0: 0x1000, mask 0xF8, wdata 0x4455667788000000; beat1: 0x1008, mask 0x07, wdata 0x0000000000112233; resp_split=1.
REQ-033 LB addr 0x2005, rdata 0x0000800000000000 -> resp_rdata 0xFFFFFFFFFFFFFF80; LBU with the same stimulus -> 0x0000000000000080.
REQ-034 LW addr 0x2006, beat0 rdata 0xBEEF000000000000, beat1 rdata 0x000000000000DEAD -> resp_rdata 0xFFFFFFFFDEADBEEF.
REQ-035 mem_ready held low for 3 cycles in BEAT0 -> all mem_* outputs stable throughout; func_code 111 -> resp_error=1, mem_valid never asserted.
REQ-036 rst asserted during BEAT1 -> mem_valid=0 on the next cycle, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/riscv_lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : riscv_lsu_align
// Brief   : RISC-V load/store alignment unit; maps byte/half/word/double
//           accesses onto an NB-byte bus, splitting lane-crossing ones in two.
// Revision: 1.0
// ============================================================================
module riscv_lsu_align #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_read,
    input  logic [2:0]          func_code,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_mask,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_error,
    output logic                resp_split
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [ADDR_W-1:0] c_BEAT_STEP = ADDR_W'(NB);
    localparam logic [4:0]        c_NB5       = 5'(NB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q;
    logic               write_q;
    logic [2:0]         func_q;
    logic [OFF_W-1:0]   off_q;
    logic [XLEN-1:0]    wdata_q;
    logic               split_q;
    logic [XLEN-1:0]    rdlo_q;

    logic [2:0]         w_func;
    logic [OFF_W-1:0]   w_off;
    logic [XLEN-1:0]    w_wdata;
    logic [4:0]         w_size;
    logic [4:0]         w_end;
    logic               w_split;
    logic               w_err;
    logic [2*NB-1:0]    w_szmask;
    logic [2*NB-1:0]    w_mwide;
    logic [2*XLEN-1:0]  w_dwide;
    logic [2*XLEN-1:0]  w_rwide;
    logic [XLEN-1:0]    w_rd_lo;
    logic [XLEN-1:0]    w_rd_hi;

    // Lane math runs on the live request while idle, on the latched copy afterwards.
    assign w_func  = (state_q == S_IDLE) ? func_code              : func_q;
    assign w_off   = (state_q == S_IDLE) ? req_addr[OFF_W-1:0]    : off_q;
    assign w_wdata = (state_q == S_IDLE) ? req_wdata              : wdata_q;

    assign w_size  = 5'd1 << w_func[1:0];
    assign w_end   = 5'(w_off) + w_size;
    assign w_split = (w_end > c_NB5);

    assign w_err = (func_code == 3'b111)
                || ((XLEN == 32) && (func_code == 3'b011))
                || (func_code[2] && req_write)
                || (req_read == req_write);

    always_comb begin
        w_szmask = '0;
        unique case (w_func[1:0])
            2'd0:    w_szmask[0]   = 1'b1;
            2'd1:    w_szmask[1:0] = '1;
            2'd2:    w_szmask[3:0] = '1;
            default: w_szmask[7:0] = '1;
        endcase
    end

    // Lower half of each double-width shift is beat 0, upper half is beat 1.
    assign w_mwide = w_szmask << w_off;
    assign w_dwide = {{XLEN{1'b0}}, w_wdata} << {w_off, 3'b000};

    // Read data shifted the other way: upper half lands low bytes, lower half the spill.
    assign w_rwide = {mem_rdata, {XLEN{1'b0}}} >> {off_q, 3'b000};
    assign w_rd_lo = w_rwide[2*XLEN-1:XLEN];
    assign w_rd_hi = w_rwide[XLEN-1:0];

    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] d,
                                                 input logic [2:0]      fc);
        logic [XLEN-1:0] r;
        int              nbits;
        logic            fill;
        nbits = 8 << fc[1:0];
        if (nbits > XLEN) nbits = XLEN;
        fill = ~fc[2] & d[nbits-1];
        r = d;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= nbits) r[i] = fill;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            resp_split <= 1'b0;
            write_q    <= 1'b0;
            func_q     <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            split_q    <= 1'b0;
            rdlo_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        func_q    <= func_code;
                        off_q     <= req_addr[OFF_W-1:0];
                        wdata_q   <= req_wdata;
                        if (w_err) begin
                            split_q    <= 1'b0;
                            state_q    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                            resp_split <= 1'b0;
                        end else begin
                            split_q   <= w_split;
                            state_q   <= S_BEAT0;
                            mem_valid <= 1'b1;
                            mem_write <= req_write;
                            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_mask  <= w_mwide[NB-1:0];
                            mem_wdata <= w_dwide[XLEN-1:0];
                        end
                    end
                end
                S_BEAT0: begin
                    if (mem_ready) begin
                        if (split_q) begin
                            state_q   <= S_BEAT1;
                            mem_addr  <= mem_addr + c_BEAT_STEP;
                            mem_mask  <= w_mwide[2*NB-1:NB];
                            mem_wdata <= w_dwide[2*XLEN-1:XLEN];
                            rdlo_q    <= w_rd_lo;
                        end else begin
                            state_q    <= S_RESP;
                            mem_valid  <= 1'b0;
                            mem_mask   <= '0;
                            mem_wdata  <= '0;
                            resp_valid <= 1'b1;
                            resp_split <= 1'b0;
                            resp_rdata <= write_q ? '0 : f_extend(w_rd_lo, func_q);
                        end
                    end
                end
                S_BEAT1: begin
                    if (mem_ready) begin
                        state_q    <= S_RESP;
                        mem_valid  <= 1'b0;
                        mem_mask   <= '0;
                        mem_wdata  <= '0;
                        resp_valid <= 1'b1;
                        resp_split <= 1'b1;
                        resp_rdata <= write_q ? '0 : f_extend(rdlo_q | w_rd_hi, func_q);
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_split <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
